// File: rtl/bcd_to_bin.sv
// Sequential 6-digit BCD to 20-bit binary converter (reverse double-dabble).
// One conversion at a time with a start/busy/done handshake.

module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd8) ? d - 4'd3 : d;
endmodule

module bcd_to_bin (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [3:0]  unit,
  input  logic [3:0]  ten,
  input  logic [3:0]  hun,
  input  logic [3:0]  tho,
  input  logic [3:0]  t_tho,
  input  logic [3:0]  h_tho,
  output logic        busy,
  output logic        done,
  output logic [19:0] bin_data,
  output logic        err
);
  localparam int NUM_DIG = 6;
  localparam int ITERS   = 20;

  typedef enum logic [1:0] {IDLE, SHIFT, ADJ} state_t;

  state_t                      state;
  logic [4:0]                  cnt;
  logic [43:0]                 work;
  logic [NUM_DIG-1:0][3:0]     dig_in;
  logic [NUM_DIG-1:0][3:0]     adj_d;
  logic                        bad;

  assign dig_in = {h_tho, t_tho, tho, hun, ten, unit};

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NUM_DIG; i++)
      if (dig_in[i] > 4'd9) bad = 1'b1;
  end

  // Every digit field is corrected in parallel from its pre-adjust value.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (work[20+4*g +: 4]),
      .q (adj_d[g])
    );
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bin_data <= '0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work <= {dig_in, 20'd0};
            cnt  <= '0;
            err  <= bad;
            if (bad) begin
              bin_data <= '0;
              done     <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= work >> 1;
          cnt   <= cnt + 5'd1;
          state <= ADJ;
        end
        ADJ: begin
          if (cnt == 5'(ITERS)) begin
            bin_data <= work[19:0];
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            work[43:20] <= adj_d;
            state       <= SHIFT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: directed plan plus random digits checked against
// a decimal-weight reference model.

module tb_bcd_to_bin;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  unit = '0, ten = '0, hun = '0, tho = '0, t_tho = '0, h_tho = '0;
  logic        busy, done, err;
  logic [19:0] bin_data;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  bcd_to_bin dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .unit      (unit),
    .ten       (ten),
    .hun       (hun),
    .tho       (tho),
    .t_tho     (t_tho),
    .h_tho     (h_tho),
    .busy      (busy),
    .done      (done),
    .bin_data  (bin_data),
    .err       (err)
  );

  function automatic int bcd_val(input logic [23:0] b);
    int s = 0;
    for (int i = 5; i >= 0; i--) s = s * 10 + int'(b[i*4 +: 4]);
    return s;
  endfunction

  function automatic bit bcd_bad(input logic [23:0] b);
    bit r = 1'b0;
    for (int i = 0; i < 6; i++) if (b[i*4 +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle; returns one step after the accepting edge.
  task automatic start_conv(input logic [23:0] b);
    {h_tho, t_tho, tho, hun, ten, unit} = b;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  // lat counts edges after the start edge at which done was seen high.
  task automatic wait_done(input int lat0, output int lat, output int bcnt);
    lat  = lat0;
    bcnt = 0;
    while (done !== 1'b1 && lat < lat0 + 100) begin
      if (busy === 1'b1) bcnt++;
      @(posedge sys_clk); #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [23:0] b, input bit chk_after);
    int lat, bcnt;
    bit bad;
    bad = bcd_bad(b);
    start_conv(b);
    wait_done(0, lat, bcnt);
    chk({tag, " latency"}, lat, bad ? 0 : 40);
    chk({tag, " busy cycles"}, bcnt, bad ? 0 : 40);
    chk({tag, " busy at done"}, busy, 0);
    chk({tag, " bin_data"}, bin_data, bad ? 0 : bcd_val(b));
    chk({tag, " err"}, err, bad);
    if (chk_after) begin
      @(posedge sys_clk); #1;
      chk({tag, " done one cycle"}, done, 0);
      chk({tag, " bin_data held"}, bin_data, bad ? 0 : bcd_val(b));
    end
  endtask

  initial begin
    int lat, bcnt;
    #2;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset bin_data", bin_data, 0);
    chk("reset err", err, 0);
    #10 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    run("zero", to_bcd(0), 1'b1);
    run("max", to_bcd(999999), 1'b1);

    // back-to-back: second start lands on the done cycle
    run("b2b first", to_bcd(123456), 1'b0);
    run("b2b second", to_bcd(1), 1'b1);

    run("bad ten", 24'h0000A0, 1'b1);
    run("after bad", to_bcd(5), 1'b1);

    // starts during a conversion are ignored
    start_conv(to_bcd(65535));
    repeat (4) @(posedge sys_clk);
    #1;
    {h_tho, t_tho, tho, hun, ten, unit} = to_bcd(999999);
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    chk("ignore bin_data held", bin_data, 5);
    repeat (14) @(posedge sys_clk);
    #1;
    {h_tho, t_tho, tho, hun, ten, unit} = 24'hA00007;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    wait_done(20, lat, bcnt);
    chk("ignore latency", lat, 40);
    chk("ignore bin_data", bin_data, 20'h0FFFF);
    chk("ignore err", err, 0);
    @(posedge sys_clk); #1;

    // reset mid-conversion
    start_conv(to_bcd(500000));
    repeat (15) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort bin_data", bin_data, 0);
    chk("abort err", err, 0);
    #2 sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    run("after abort", to_bcd(500000), 1'b1);
    chk("after abort value", bin_data, 20'h7A120);

    // random digits, every fourth one allowed to contain invalid digits
    for (int i = 0; i < 30; i++) begin
      logic [23:0] b;
      for (int j = 0; j < 6; j++)
        b[j*4 +: 4] = (i % 4 == 3) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      run($sformatf("rand%0d", i), b, (i % 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
